// File: rtl/regfile_sequencer.sv
// Three-state instruction sequencer for a 4 x 8-bit register file.
// Each instruction is read in EXEC, computed in an internal ALU and written back in WB.
module regfile_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  input  logic        hold,
  input  logic [7:0]  operand_a,
  input  logic [7:0]  operand_b,
  output logic [1:0]  a_sel,
  output logic [1:0]  b_sel,
  output logic [1:0]  dest_sel,
  output logic        load_enable,
  output logic [7:0]  reg_data,
  output logic        done,
  output logic        illegal,
  output logic        zero_flag,
  output logic        carry_flag,
  output logic [7:0]  retired_count
);

  // state | meaning
  // IDLE  | instr_ready high, waiting for a valid instruction
  // EXEC  | read selects driven from ir, ALU result captured when hold is low
  // WB    | write strobe and done pulse when hold is low, then retire
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_MOV = 4'd6;
  localparam logic [3:0] OP_LDI = 4'd7;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  res_q, res_d;
  logic        zero_q, zero_d;
  logic        carry_q, carry_d;
  logic [7:0]  count_q, count_d;

  logic [3:0]  op;
  logic        writes;
  logic        is_arith;
  logic [8:0]  sum9;
  logic [8:0]  diff9;
  logic [7:0]  alu_res;
  logic        alu_carry;

  assign op       = ir_q[15:12];
  assign writes   = (op != 4'd0) && !op[3];
  assign is_arith = (op == OP_ADD) || (op == OP_SUB);
  assign sum9     = {1'b0, operand_a} + {1'b0, operand_b};
  assign diff9    = {1'b0, operand_a} - {1'b0, operand_b};

  // SUB reports no-borrow, i.e. carry is set when A >= B
  always_comb begin
    alu_res   = 8'h00;
    alu_carry = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res   = sum9[7:0];
        alu_carry = sum9[8];
      end
      OP_SUB: begin
        alu_res   = diff9[7:0];
        alu_carry = ~diff9[8];
      end
      OP_AND:  alu_res = operand_a & operand_b;
      OP_OR:   alu_res = operand_a | operand_b;
      OP_XOR:  alu_res = operand_a ^ operand_b;
      OP_MOV:  alu_res = operand_a;
      OP_LDI:  alu_res = ir_q[7:0];
      default: alu_res = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!hold) begin
          res_d   = alu_res;
          state_d = S_WB;
          if (is_arith) carry_d = alu_carry;
          if (writes)   zero_d  = (alu_res == 8'h00);
        end
      end
      S_WB: begin
        if (!hold) begin
          count_d = count_q + 8'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= 16'h0000;
      res_q   <= 8'h00;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      count_q <= 8'h00;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
      count_q <= count_d;
    end
  end

  // Strobes depend on hold directly so a held WB never writes
  logic busy;
  logic in_wb;

  assign busy          = (state_q != S_IDLE);
  assign in_wb         = (state_q == S_WB);
  assign instr_ready   = !busy;
  assign a_sel         = busy ? ir_q[9:8]   : 2'd0;
  assign b_sel         = busy ? ir_q[7:6]   : 2'd0;
  assign dest_sel      = busy ? ir_q[11:10] : 2'd0;
  assign done          = in_wb && !hold;
  assign load_enable   = done && writes;
  assign illegal       = done && op[3];
  assign reg_data      = in_wb ? res_q : 8'h00;
  assign zero_flag     = zero_q;
  assign carry_flag    = carry_q;
  assign retired_count = count_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: directed table, random instructions against a model, corner sequences.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = 16'h0000;
  logic        hold = 1'b0;
  logic [7:0]  operand_a, operand_b;
  logic [1:0]  a_sel, b_sel, dest_sel;
  logic        load_enable;
  logic [7:0]  reg_data;
  logic        done, illegal, zero_flag, carry_flag;
  logic [7:0]  retired_count;

  regfile_sequencer dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .hold(hold), .operand_a(operand_a), .operand_b(operand_b),
    .a_sel(a_sel), .b_sel(b_sel), .dest_sel(dest_sel), .load_enable(load_enable),
    .reg_data(reg_data), .done(done), .illegal(illegal), .zero_flag(zero_flag),
    .carry_flag(carry_flag), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  // Register file written only by the DUT's strobe; it feeds the operands back
  logic [7:0] rf [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  assign operand_a = rf[a_sel];
  assign operand_b = rf[b_sel];
  always @(posedge clk) if (load_enable) rf[dest_sel] <= reg_data;

  typedef struct {
    logic       le;
    logic [1:0] dest;
    logic [7:0] data;
    logic       ill;
    logic       z;
    logic       c;
    logic [7:0] cnt;
  } exp_t;

  typedef struct {
    logic [15:0] ins;
    int          eh;
    int          wh;
    logic        le;
    logic [1:0]  dest;
    logic [7:0]  data;
    logic        ill;
    logic        z;
    logic        c;
  } vec_t;

  int total = 0;
  int bad = 0;
  int le_cnt = 0;
  int done_cnt = 0;

  exp_t exp_q[$];
  exp_t mon_e;
  logic       last_le, last_ill, last_z, last_c;
  logic [1:0] last_dest;
  logic [7:0] last_data;

  logic [7:0] mrf [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  logic       mz = 1'b0;
  logic       mc = 1'b0;
  logic [7:0] mcnt = 8'h00;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model: what one instruction should do, in plain integer arithmetic
  task automatic model_push(input logic [15:0] ins);
    exp_t e;
    int op, a, b, r;
    op = int'(ins[15:12]);
    a  = int'(mrf[ins[9:8]]);
    b  = int'(mrf[ins[7:6]]);
    r  = 0;
    case (op)
      1: begin r = a + b; mc = (r > 255); end
      2: begin mc = (a >= b); r = a - b; if (r < 0) r = r + 256; end
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = a;
      7: r = int'(ins[7:0]);
      default: r = 0;
    endcase
    r = r % 256;
    e.le   = (op >= 1 && op <= 7);
    e.dest = ins[11:10];
    e.data = r[7:0];
    e.ill  = (op >= 8);
    if (e.le) begin
      mz = (r == 0);
      mrf[ins[11:10]] = r[7:0];
    end
    e.z   = mz;
    e.c   = mc;
    e.cnt = mcnt;
    mcnt  = mcnt + 8'd1;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (load_enable) le_cnt++;
      if (load_enable && !done) chk("le_without_done", 1, 0);
      if (done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_done: got done=1 expected no retirement at %0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ret_load_enable", int'(load_enable), int'(mon_e.le));
          chk("ret_illegal", int'(illegal), int'(mon_e.ill));
          chk("ret_zero", int'(zero_flag), int'(mon_e.z));
          chk("ret_carry", int'(carry_flag), int'(mon_e.c));
          chk("ret_count", int'(retired_count), int'(mon_e.cnt));
          if (mon_e.le) begin
            chk("ret_dest", int'(dest_sel), int'(mon_e.dest));
            chk("ret_data", int'(reg_data), int'(mon_e.data));
          end
          last_le   = load_enable;
          last_ill  = illegal;
          last_z    = zero_flag;
          last_c    = carry_flag;
          last_dest = dest_sel;
          last_data = reg_data;
        end
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!instr_ready) chk("ready_timeout", 0, 1);
  endtask

  // Entered and left at 1 time unit after a rising edge, with the sequencer idle
  task automatic issue(input logic [15:0] ins, input int eh, input int wh);
    wait_ready();
    model_push(ins);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    chk("exec_ready_low", int'(instr_ready), 0);
    hold = (eh > 0);
    repeat (eh) @(posedge clk);
    #1 hold = 1'b0;
    @(posedge clk);
    #1;
    chk("wb_ready_low", int'(instr_ready), 0);
    hold = (wh > 0);
    repeat (wh) @(posedge clk);
    #1 hold = 1'b0;
    @(posedge clk);
    #1;
  endtask

  vec_t        vt [15];
  logic [15:0] sl [4];

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int le0, d0, idx, cyc, last;
    logic [31:0] rnd;
    logic [3:0]  op4;

    vt[0]  = '{16'h7405, 0, 0, 1'b1, 2'd1, 8'h05, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{16'h7803, 0, 0, 1'b1, 2'd2, 8'h03, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{16'h1D80, 0, 0, 1'b1, 2'd3, 8'h08, 1'b0, 1'b0, 1'b0};
    vt[3]  = '{16'h2280, 0, 0, 1'b1, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1};
    vt[4]  = '{16'h74FF, 0, 0, 1'b1, 2'd1, 8'hFF, 1'b0, 1'b0, 1'b1};
    vt[5]  = '{16'h7801, 0, 0, 1'b1, 2'd2, 8'h01, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{16'h1D80, 0, 0, 1'b1, 2'd3, 8'h00, 1'b0, 1'b1, 1'b1};
    vt[7]  = '{16'hB000, 0, 0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b1};
    vt[8]  = '{16'h70AA, 0, 3, 1'b1, 2'd0, 8'hAA, 1'b0, 1'b0, 1'b1};
    vt[9]  = '{16'h3C40, 0, 0, 1'b1, 2'd3, 8'hAA, 1'b0, 1'b0, 1'b1};
    vt[10] = '{16'h5800, 2, 0, 1'b1, 2'd2, 8'h00, 1'b0, 1'b1, 1'b1};
    vt[11] = '{16'h6700, 0, 0, 1'b1, 2'd1, 8'hAA, 1'b0, 1'b0, 1'b1};
    vt[12] = '{16'h4240, 0, 1, 1'b1, 2'd0, 8'hAA, 1'b0, 1'b0, 1'b1};
    vt[13] = '{16'h0000, 1, 1, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1};
    vt[14] = '{16'h2E40, 0, 0, 1'b1, 2'd3, 8'h56, 1'b0, 1'b0, 1'b0};

    #1 reset = 1'b1;
    #2;
    chk("rst_ready", int'(instr_ready), 1);
    chk("rst_sel", int'({a_sel, b_sel, dest_sel}), 0);
    chk("rst_strobes", int'({load_enable, done, illegal}), 0);
    chk("rst_reg_data", int'(reg_data), 0);
    chk("rst_flags", int'({zero_flag, carry_flag}), 0);
    chk("rst_count", int'(retired_count), 0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      le0 = le_cnt;
      d0  = done_cnt;
      issue(vt[i].ins, vt[i].eh, vt[i].wh);
      chk("tbl_done_pulses", done_cnt - d0, 1);
      chk("tbl_le_pulses", le_cnt - le0, int'(vt[i].le));
      chk("tbl_illegal", int'(last_ill), int'(vt[i].ill));
      chk("tbl_zero", int'(last_z), int'(vt[i].z));
      chk("tbl_carry", int'(last_c), int'(vt[i].c));
      if (vt[i].le) begin
        chk("tbl_dest", int'(last_dest), int'(vt[i].dest));
        chk("tbl_data", int'(last_data), int'(vt[i].data));
      end
    end
    chk("tbl_count", int'(retired_count), 15);

    for (int i = 0; i < 80; i++) begin
      rnd = $urandom;
      op4 = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      issue({op4, rnd[11:0]}, $urandom_range(0, 2), $urandom_range(0, 2));
    end
    for (int r = 0; r < 4; r++) chk("rnd_regfile", int'(rf[r]), int'(mrf[r]));

    sl[0] = 16'h7411;
    sl[1] = 16'h7822;
    sl[2] = 16'h1D80;
    sl[3] = 16'h2340;
    for (int i = 0; i < 4; i++) model_push(sl[i]);
    d0 = done_cnt;
    idx = 0;
    cyc = 0;
    last = -1;
    instr = sl[0];
    instr_valid = 1'b1;
    while (idx < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (instr_ready) begin
        if (last >= 0) chk("stream_gap", cyc - last, 3);
        last = cyc;
        @(posedge clk);
        #1;
        idx++;
        if (idx < 4) instr = sl[idx];
        else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    chk("stream_accepts", idx, 4);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 40) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    chk("stream_drained", exp_q.size(), 0);
    chk("stream_done_pulses", done_cnt - d0, 4);
    chk("stream_dep_r0", int'(rf[0]), 8'h22);

    wait_ready();
    le0 = le_cnt;
    instr = 16'h1D80;
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_ready", int'(instr_ready), 1);
    chk("abort_le", int'(load_enable), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_count", int'(retired_count), 0);
    chk("abort_sel", int'({a_sel, b_sel}), 0);
    mz = 1'b0;
    mc = 1'b0;
    mcnt = 8'h00;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_write", le_cnt - le0, 0);
    chk("abort_count_after", int'(retired_count), 0);

    for (int i = 0; i < 256; i++) issue(16'h0000, 0, 0);
    chk("wrap_count", int'(retired_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Multi-cycle instruction sequencer that owns the 4 x 8-bit register file's control inputs. It accepts one 16-bit instruction at a time over a valid/ready handshake and drives the A/B read selects and the destination select. It executes the operation on the returned operands in an internal 8-bit ALU and issues a single write-enable pulse to commit the result. It sits between the instruction source (test ROM or top-level FSM) and the register file.

## Interface
- Parameters: none (widths fixed: 8-bit data, 4 registers, 16-bit instruction).
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- instr_valid  in  1  instruction present on instr
- instr_ready  out  1  sequencer can accept an instruction
- instr  in  16  [15:12] opcode, [11:10] dest, [9:8] srcA, [7:6] srcB, [7:0] imm (LDI only)
- hold  in  1  freezes EXEC/WB progress while high
- operand_a  in  8  register file read port A data
- operand_b  in  8  register file read port B data
- a_sel  out  2  register file read port A select
- b_sel  out  2  register file read port B select
- dest_sel  out  2  register file write destination
- load_enable  out  1  register file write strobe
- reg_data  out  8  register file write data
- done  out  1  one-cycle pulse when an instruction retires
- illegal  out  1  high with done when retired opcode was undefined
- zero_flag  out  1  result == 0 of last ALU-class instruction
- carry_flag  out  1  carry-out (ADD) / no-borrow (SUB) of last ADD/SUB
- retired_count  out  8  instructions retired, wraps 255 -> 0

## Operation
- Opcodes: 0 NOP, 1 ADD, 2 SUB (A-B), 3 AND, 4 OR, 5 XOR, 6 MOV (dest<=A), 7 LDI (dest<=imm), 8-15 illegal.
- States: IDLE -> EXEC -> WB -> IDLE.
- IDLE: instr_ready=1.
  - On instr_valid&instr_ready at an edge, latch instr into ir and go EXEC.
  - Otherwise stay.
- EXEC: a_sel=ir[9:8], b_sel=ir[7:6]; ALU computes from operand_a/operand_b combinationally.
  - At an edge with hold=0: capture the 8-bit result into res_q. ADD/SUB also update carry_flag. Opcodes 1-7 update zero_flag.
  - Then go WB.
- WB: dest_sel=ir[11:10], reg_data=res_q; load_enable = ~hold & writes(op); done = ~hold.
  - writes(op)=1 for opcodes 1-7 only.
  - At an edge with hold=0: increment retired_count and go IDLE.
- NOP and illegal: full three-state path, no write, flags unchanged; illegal=1 during the done cycle.
- Arithmetic: 9-bit sum/difference, low 8 bits to result. SUB carry = 1 when A >= B (unsigned).
- a_sel/b_sel keep their ir values during WB; all selects read 0 in IDLE.

## Timing
- Reset values: state IDLE, instr_ready=1, a_sel=b_sel=dest_sel=0, load_enable=0, reg_data=0, done=0, illegal=0, zero_flag=0, carry_flag=0, retired_count=0, ir=0, res_q=0.
- Accept at edge E0. EXEC spans E0-E1. WB spans E1-E2. The register file captures at E2. instr_ready returns high after E2.
- Throughput: one instruction per 3 cycles with hold=0.
- instr_ready is low in EXEC and WB. instr_valid there is ignored, and the source must hold it.
- hold=1 in EXEC: state and res_q frozen, selects stay driven.
- hold=1 in WB: load_enable=0 and done=0; the write occurs on the first edge with hold=0.
- hold in IDLE has no effect; acceptance is still allowed.
- Back-to-back dependency (write R1, then read R1): the result is visible because the write commits at E2, before the next EXEC.
- Reset asserted mid-instruction: the instruction is aborted with no write, and outputs go to reset values immediately.
- retired_count wraps 255 -> 0 without a flag.

## Test plan
- Reset, then LDI R1,0x05 and LDI R2,0x03 → load_enable pulses with dest_sel=1, reg_data=0x05 and dest_sel=2, reg_data=0x03; retired_count=2.
- ADD R3=R1+R2 with operand_a=0x05, operand_b=0x03 → reg_data=0x08, dest_sel=3, carry=0, zero=0. SUB R0=R2-R2 → 0x00, zero=1, carry=1.
- ADD with 0xFF+0x01 → reg_data=0x00, carry_flag=1, zero_flag=1. Opcode 0xB → done=1, illegal=1, no load_enable, flags unchanged.
- Hold asserted for 3 cycles in WB of LDI R0,0xAA → load_enable stays 0 during hold and goes high for exactly one cycle after release; done is a single pulse.
- instr_valid held high continuously with 4 instructions → exactly one acceptance per 3 cycles, 4 done pulses, instr_ready low in EXEC/WB.
- Reset asserted in EXEC of ADD → no load_enable, retired_count=0, instr_ready=1 without waiting for a clock edge. 256 NOPs → retired_count wraps to 0.
